load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store engine between the Control_Unit and data memory; successor to the
//  single-cycle LOAD path that writes instruction-encoded data straight into register_file.
//  Accepts one request at a time, handshakes with memory, sizes and extends load data, and
//  issues a one-cycle writeback (WE3/A3/WD3) to register_file. Parametrised in word width.
// PARAMETERS
//  WORD_SIZE      32  data/memory width in bits; legal values 32 or 64
//  ADDR_W         32  byte address width
//  REG_ADDR_W     9   destination register index width (matches register_file A3)
//  TIMEOUT_CYCLES 16  max wait for mem_ack (used only with LSU_TIMEOUT_EN)
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous, active-high reset
//  req_valid    in   1              request present
//  req_ready    out  1              LSU can accept (IDLE only)
//  req_store    in   1              1 = store, 0 = load
//  req_size     in   2              00 byte, 01 half, 10 word, 11 dword (WORD_SIZE=64 only)
//  req_signed   in   1              load: 1 sign-extend, 0 zero-extend
//  req_addr     in   ADDR_W         byte address
//  req_wdata    in   WORD_SIZE      store data, right-justified
//  req_rd       in   REG_ADDR_W     load destination register
//  mem_req      out  1              memory access request, held until mem_ack
//  mem_we       out  1              memory write enable
//  mem_addr     out  ADDR_W         word-aligned address (low log2(WORD_SIZE/8) bits zero)
//  mem_wdata    out  WORD_SIZE      store data replicated into all lanes of its size
//  mem_be       out  WORD_SIZE/8    byte enables
//  mem_ack      in   1              memory completion; mem_rdata valid same cycle
//  mem_rdata    in   WORD_SIZE      load data, full word
//  wb_valid     out  1              one-cycle pulse -> register_file WE3
//  wb_rd        out  REG_ADDR_W     -> A3
//  wb_data      out  WORD_SIZE      extended load data -> WD3
//  done         out  1              one-cycle pulse: store complete or load written back
//  err          out  1              one-cycle pulse: misaligned/illegal size (or timeout)
// BEHAVIOUR
//  - Reset (any time, async): state IDLE; req_ready=1; every other output 0; in-flight access
//    abandoned, no wb/done/err; counter cleared.
//  - FSM IDLE -> ACCESS -> (WB) -> IDLE; ERR is a one-cycle state returning to IDLE.
//  - IDLE: accept on req_valid&&req_ready; latch all req_* fields. Misaligned (half addr[0]!=0,
//    word addr[1:0]!=0, dword addr[2:0]!=0) or size 11 with WORD_SIZE=32 -> ERR: err=1 one
//    cycle, no mem_req. Otherwise -> ACCESS.
//  - ACCESS: mem_req=1, mem_we=req_store; mem_addr/mem_wdata/mem_be stable until ack.
//    mem_be: byte 1 bit at lane addr offset, half 2 bits, word 4, dword all.
//  - Ack in ACCESS: store -> done=1 next cycle, IDLE. Load -> extract addressed lane, sign- or
//    zero-extend to WORD_SIZE, register into wb_data; WB: wb_valid=1 and done=1 one cycle.
//  - Latency: accept cycle N, mem_req from N+1; ack at N+1 earliest -> wb_valid/done at N+2.
//  - mem_ack outside ACCESS ignored. req_ready=0 in ACCESS/WB/ERR; requests then are held
//    off, never dropped silently (requester keeps req_valid).
//  - wb_rd/wb_data hold last values when wb_valid=0; consumers qualify on wb_valid only.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: ACCESS counts cycles; if no mem_ack within TIMEOUT_CYCLES cycles
//    of mem_req rising, mem_req drops, err=1 one cycle, IDLE, no writeback. Ack on the final
//    counted cycle wins over timeout.
//  Not defined: no counter; ACCESS waits indefinitely for mem_ack.
// TESTING
//  1 Load word, addr 0x10, rd=5, ack after 3 cycles, rdata 0xDEADBEEF -> mem_addr 0x10,
//    mem_be 4'b1111, wb_valid one cycle with wb_rd=5, wb_data 0xDEADBEEF.
//  2 Load byte signed, addr 0x13, rdata 0x80FF_FF7F -> be 4'b1000, wb_data 0xFFFFFF80;
//    unsigned same -> 0x00000080.
//  3 Store half 0xABCD at 0x22 -> mem_we=1, mem_addr 0x20, mem_be 4'b1100,
//    mem_wdata 0xABCDABCD; done one cycle after ack, wb_valid never set.
//  4 Load word at 0x06 / size 11 with WORD_SIZE=32 -> err one cycle, mem_req stays 0.
//  5 rst asserted mid-ACCESS before ack -> mem_req 0 immediately, no wb; later ack ignored;
//    next request completes normally.
//  6 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> mem_req high 4 cycles, then err, IDLE;
//    WORD_SIZE=64 dword load at 0x08 -> mem_be 8'hFF, full 64-bit wb_data.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: one request at a time, memory handshake, lane sizing and
// load extension, one-cycle writeback pulse. Optional LSU_TIMEOUT_EN bounds the mem_ack wait.
module load_store_unit #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned REG_ADDR_W     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_store,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [WORD_SIZE-1:0]   req_wdata,
    input  logic [REG_ADDR_W-1:0]  req_rd,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    output logic [WORD_SIZE/8-1:0] mem_be,
    input  logic                   mem_ack,
    input  logic [WORD_SIZE-1:0]   mem_rdata,
    output logic                   wb_valid,
    output logic [REG_ADDR_W-1:0]  wb_rd,
    output logic [WORD_SIZE-1:0]   wb_data,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned NB    = WORD_SIZE / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    if (!(WORD_SIZE == 32 || WORD_SIZE == 64)) begin : g_bad_word_size
        $error("load_store_unit: WORD_SIZE must be 32 or 64");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB, S_ERR} state_e;

    state_e                  state_q, state_d;
    logic                    store_q, store_d;
    logic [1:0]              size_q, size_d;
    logic                    signed_q, signed_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    req_ready_q, req_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]           mem_be_q, mem_be_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0]   wb_rd_q, wb_rd_d;
    logic [WORD_SIZE-1:0]    wb_data_q, wb_data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [OFF_W-1:0]        off_c;
    logic                    illegal_c;
    logic [NB-1:0]           be_c;
    logic [WORD_SIZE-1:0]    wdata_rep_c;
    logic [WORD_SIZE-1:0]    shifted_c;
    logic [WORD_SIZE-1:0]    mask_c;
    logic                    sbit_c;
    logic [WORD_SIZE-1:0]    load_ext_c;
    logic                    tmo_c;

    assign off_c = req_addr[OFF_W-1:0];

    // Request decode: alignment check, byte enables and lane replication of store data
    always_comb begin
        illegal_c   = 1'b0;
        be_c        = '0;
        wdata_rep_c = '0;
        case (req_size)
            2'b00: begin
                be_c = NB'(1) << off_c;
            end
            2'b01: begin
                illegal_c = req_addr[0];
                be_c      = NB'(3) << off_c;
            end
            2'b10: begin
                illegal_c = |req_addr[1:0];
                be_c      = NB'(15) << off_c;
            end
            default: begin
                illegal_c = (WORD_SIZE != 64) || (|req_addr[2:0]);
                be_c      = '1;
            end
        endcase
        for (int i = 0; i < int'(NB); i++) begin
            case (req_size)
                2'b00:   wdata_rep_c[8*i +: 8] = req_wdata[7:0];
                2'b01:   wdata_rep_c[8*i +: 8] = req_wdata[8*(i%2) +: 8];
                2'b10:   wdata_rep_c[8*i +: 8] = req_wdata[8*(i%4) +: 8];
                default: wdata_rep_c[8*i +: 8] = req_wdata[8*i +: 8];
            endcase
        end
    end

    // Load lane extraction: shift addressed lane down, then sign- or zero-fill above it
    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00: begin
                mask_c = WORD_SIZE'(8'hFF);
                sbit_c = shifted_c[7];
            end
            2'b01: begin
                mask_c = WORD_SIZE'(16'hFFFF);
                sbit_c = shifted_c[15];
            end
            2'b10: begin
                mask_c = WORD_SIZE'(32'hFFFF_FFFF);
                sbit_c = shifted_c[31];
            end
            default: begin
                mask_c = '1;
                sbit_c = 1'b0;
            end
        endcase
        load_ext_c = (shifted_c & mask_c) | ((signed_q && sbit_c) ? ~mask_c : '0);
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles spent in ACCESS; an ack on the last counted cycle still wins
    always_comb begin
        cnt_d = '0;
        if (state_q == S_ACCESS && state_d == S_ACCESS) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tmo_c = (state_q == S_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    store_d  = req_store;
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = off_c;
                    rd_d     = req_rd;
                    if (illegal_c) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_wdata_d = wdata_rep_c;
                        mem_be_d    = be_c;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    done_d = 1'b1;
                    if (store_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_ext_c;
                    end
                end else if (tmo_c) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        mem_req_d   = (state_d == S_ACCESS);
        mem_we_d    = mem_req_d && store_d;
        if (!mem_req_d) begin
            mem_be_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= '0;
            rd_q        <= '0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
